parking_gate_ctrl: RTL
======================

// Module: parking_gate_ctrl
// PURPOSE
//  Drives the door block's open_signal input from the entry/exit car sensors.
//  - Tracks free parking spaces; grants or denies entry accordingly.
//  - Issues exactly one single-cycle open pulse per granted passage.
//  - Holds off further pulses until the door's blink cycle has finished.
//  - Sits between the sensor inputs and the door; runs on the same 2 Hz clock.
// PARAMETERS
//  CAPACITY     8   total spaces; free_count reset value and saturation ceiling
//  CNT_W        4   width of free_count; must satisfy 2**CNT_W > CAPACITY
//  HOLD_CYCLES  22  clk_2Hz cycles busy after a grant; door needs 22, must be >= 22
// PORTS
//  clk_2Hz     in   1      system clock, 2 Hz, rising edge
//  reset       in   1      asynchronous, active-low reset
//  entry_req   in   1      entry sensor level; rising edge = car wants in
//  exit_req    in   1      exit sensor level; rising edge = car wants out
//  open_signal out  1      one-cycle pulse to the door block
//  busy        out  1      1 while door cycle in progress (state HOLD)
//  free_count  out  CNT_W  number of free spaces
//  full        out  1      free_count == 0
//  denied      out  1      one-cycle pulse: entry refused, lot full
//  err         out  1      one-cycle pulse: exit request with lot empty (dropped)
// BEHAVIOUR
//  Reset values: open_signal=0, busy=0, denied=0, err=0, free_count=CAPACITY,
//    full=0, state=IDLE, pending flags=0, hold_cnt=0, edge-detect regs=0.
//  All outputs registered; full is decoded from registered free_count.
//  Edge detect: prev-sample reg per sensor; rise = req & ~prev.
//    A rise sets entry_pend / exit_pend at that edge.
//    A rise while already pending is merged (one pending per direction).
//  FSM states: IDLE, HOLD.
//  IDLE, exit_pend=1:
//    free_count<CAPACITY: open_signal<=1, free_count+1, exit_pend<=0, busy<=1,
//      hold_cnt<=0, ->HOLD.
//    free_count==CAPACITY: err<=1, exit_pend<=0, stay IDLE.
//  IDLE, exit_pend=0, entry_pend=1:
//    free_count>0: open_signal<=1, free_count-1, entry_pend<=0, busy<=1,
//      hold_cnt<=0, ->HOLD.
//    free_count==0: denied<=1, entry_pend<=0, stay IDLE.
//  Exit has priority over entry when both pend; entry stays pending.
//  HOLD: open_signal<=0; hold_cnt+1 each edge.
//    On the edge where hold_cnt==HOLD_CYCLES-1: busy<=0, ->IDLE.
//    Requests arriving in HOLD are latched, served on the first IDLE edge.
//  Latency: sensor rise sampled at edge k -> open_signal high from edge k+2
//    for exactly 1 cycle (if IDLE at k+1).
//  Pulse spacing: consecutive open pulses are >= HOLD_CYCLES+1 edges apart
//    (23 at default).
//  denied and err self-clear after 1 cycle. Only one action per IDLE edge.
//  free_count never wraps: no increment at CAPACITY, no decrement at 0.
//  Reset asserted mid-HOLD: everything returns to reset values; pending
//    requests are discarded; free_count reloads CAPACITY.
//  Sensor held high: counts as one request; a new rise needs a low sample.
// TESTING
//  1. Reset, entry_req 0->1 sampled at edge 3 -> open_signal=1 only in the
//     cycle after edge 5; free_count 8->7; busy high 22 cycles.
//  2. 8 spaced entries -> free_count=0, full=1; 9th entry -> denied pulse,
//     no open_signal, count stays 0.
//  3. entry_req and exit_req rise at the same edge with free_count=3 -> exit
//     served first (count 4); entry opens 23 edges later (count 3).
//  4. Two entry rises during HOLD -> exactly one open pulse after HOLD ends
//     (merged request).
//  5. exit_req rise with free_count=8 -> err pulse, no open, count stays 8.
//  6. reset low at HOLD cycle 10 with entry_pend=1 -> all outputs at reset
//     values; free_count=8; no open pulse after release.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl
// Turns the entry/exit car sensors into single-cycle open pulses for the door
// block, keeps the free-space count, and holds off new pulses while the door
// runs its blink cycle. All logic runs on the 2 Hz system clock.
// HOLD_CYCLES must be at least 22, and 2**CNT_W must be greater than CAPACITY.
module parking_gate_ctrl #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int HOLD_CYCLES = 22
) (
  input  logic             clk_2Hz,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic             open_signal,
  output logic             busy,
  output logic [CNT_W-1:0] free_count,
  output logic             full,
  output logic             denied,
  output logic             err
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CapVal  = CNT_W'(CAPACITY);
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } stateT;

  stateT             state_q;
  logic [HOLD_W-1:0] holdCnt_q;
  logic              entrySample_q;
  logic              entryPrev_q;
  logic              exitSample_q;
  logic              exitPrev_q;
  logic              entryPend_q;
  logic              exitPend_q;
  logic              openSignal_q;
  logic              busy_q;
  logic              denied_q;
  logic              err_q;
  logic [CNT_W-1:0]  freeCount_q;

  logic              entryRise;
  logic              exitRise;
  logic              exitTaken;
  logic              entryTaken;

  // The sensors are sampled into a register first, so a rise is detected
  // between two registered samples; a held level only ever yields one rise.
  always_ff @(posedge clk_2Hz or negedge reset) begin
    if (!reset) begin
      entrySample_q <= 1'b0;
      entryPrev_q   <= 1'b0;
      exitSample_q  <= 1'b0;
      exitPrev_q    <= 1'b0;
    end else begin
      entrySample_q <= entry_req;
      entryPrev_q   <= entrySample_q;
      exitSample_q  <= exit_req;
      exitPrev_q    <= exitSample_q;
    end
  end

  // Decide which pending request the IDLE state consumes this edge; exit
  // always wins so a leaving car can free a space for a waiting entry.
  always_comb begin
    entryRise  = entrySample_q & ~entryPrev_q;
    exitRise   = exitSample_q & ~exitPrev_q;
    exitTaken  = 1'b0;
    entryTaken = 1'b0;
    if (state_q == IDLE) begin
      exitTaken  = exitPend_q;
      entryTaken = ~exitPend_q & entryPend_q;
    end
  end

  // Gate FSM with registered outputs: at most one action per IDLE edge,
  // then a fixed hold while the door blinks. Rises during HOLD stay pending.
  always_ff @(posedge clk_2Hz or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      holdCnt_q    <= '0;
      entryPend_q  <= 1'b0;
      exitPend_q   <= 1'b0;
      openSignal_q <= 1'b0;
      busy_q       <= 1'b0;
      denied_q     <= 1'b0;
      err_q        <= 1'b0;
      freeCount_q  <= CapVal;
    end else begin
      entryPend_q  <= (entryPend_q & ~entryTaken) | entryRise;
      exitPend_q   <= (exitPend_q & ~exitTaken) | exitRise;
      openSignal_q <= 1'b0;
      denied_q     <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (exitTaken) begin
            if (freeCount_q < CapVal) begin
              openSignal_q <= 1'b1;
              freeCount_q  <= freeCount_q + 1'b1;
              busy_q       <= 1'b1;
              holdCnt_q    <= '0;
              state_q      <= HOLD;
            end else begin
              err_q <= 1'b1;
            end
          end else if (entryTaken) begin
            if (freeCount_q != '0) begin
              openSignal_q <= 1'b1;
              freeCount_q  <= freeCount_q - 1'b1;
              busy_q       <= 1'b1;
              holdCnt_q    <= '0;
              state_q      <= HOLD;
            end else begin
              denied_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (holdCnt_q == HoldLast) begin
            holdCnt_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            holdCnt_q <= holdCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign open_signal = openSignal_q;
  assign busy        = busy_q;
  assign free_count  = freeCount_q;
  assign full        = (freeCount_q == '0);
  assign denied      = denied_q;
  assign err         = err_q;

endmodule
